// File: rtl/keypad_ctrl.sv
// Keypad front end for a 3x3 O/X classifier: debounced key acceptance, grid editing, MLP handshake with timeout.
// Latency: 2-cycle input sync, key acts 1 cycle after acceptance; no backpressure, keys arriving while busy are consumed.
module keypad_ctrl #(
    parameter int RELEASE_CYCLES = 25000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] key_code,
    input  logic        key_valid,
    input  logic        mlp_done,
    input  logic [1:0]  mlp_result,
    output logic [8:0]  grid,
    output logic        mlp_start,
    output logic        busy,
    output logic [1:0]  result,
    output logic        result_valid,
    output logic        timeout_err,
    output logic        key_pulse
);

    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] REL_MAX = RW'(RELEASE_CYCLES);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        EDIT  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        SHOW  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic          kv_meta, kv_sync;
    logic [11:0]   kc_meta, kc_sync;
    logic [RW-1:0] rel_cnt;
    logic          armed;
    logic          key_accept;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic [8:0]    grid_n;
    logic [1:0]    result_n;
    logic          result_valid_n, timeout_err_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kv_meta <= 1'b0;
            kv_sync <= 1'b0;
            kc_meta <= '0;
            kc_sync <= '0;
        end else begin
            kv_meta <= key_valid;
            kv_sync <= kv_meta;
            kc_meta <= key_code;
            kc_sync <= kc_meta;
        end
    end

    // Malformed codes (zero or several bits) never consume the arm.
    assign key_accept = armed && kv_sync && $onehot(kc_sync);
    assign key_pulse  = key_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rel_cnt <= '0;
            armed   <= 1'b1;
        end else begin
            if (kv_sync)
                rel_cnt <= '0;
            else if (rel_cnt != REL_MAX)
                rel_cnt <= rel_cnt + 1'b1;

            if (key_accept)
                armed <= 1'b0;
            else if (rel_cnt == REL_MAX)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= EDIT;
            grid         <= '0;
            result       <= 2'b00;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            to_cnt       <= '0;
        end else begin
            state        <= state_n;
            grid         <= grid_n;
            result       <= result_n;
            result_valid <= result_valid_n;
            timeout_err  <= timeout_err_n;
            to_cnt       <= to_cnt_n;
        end
    end

    always_comb begin
        state_n        = state;
        grid_n         = grid;
        result_n       = result;
        result_valid_n = result_valid;
        timeout_err_n  = timeout_err;
        to_cnt_n       = to_cnt;
        mlp_start      = 1'b0;
        busy           = 1'b0;

        case (state)
            EDIT, SHOW: begin
                if (key_accept) begin
                    // Any key dismisses a shown result before acting as an edit key.
                    if (state == SHOW) begin
                        result_valid_n = 1'b0;
                        timeout_err_n  = 1'b0;
                        state_n        = EDIT;
                    end
                    if (kc_sync[11]) begin
                        state_n        = START;
                        result_valid_n = 1'b0;
                        timeout_err_n  = 1'b0;
                    end else if (kc_sync[10]) begin
                        result_valid_n = 1'b0;
                        timeout_err_n  = 1'b0;
                    end else if (kc_sync[9]) begin
                        grid_n = '0;
                    end else begin
                        grid_n = grid ^ kc_sync[8:0];
                    end
                end
            end
            START: begin
                mlp_start      = 1'b1;
                busy           = 1'b1;
                result_valid_n = 1'b0;
                timeout_err_n  = 1'b0;
                to_cnt_n       = '0;
                state_n        = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                // A completion in the expiry cycle still counts as success.
                if (mlp_done) begin
                    result_n       = mlp_result;
                    result_valid_n = 1'b1;
                    state_n        = SHOW;
                end else if (to_cnt == TO_MAX) begin
                    timeout_err_n = 1'b1;
                    state_n       = SHOW;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            default: state_n = EDIT;
        endcase
    end

endmodule

// File: tb/tb_keypad_ctrl.sv
// Directed bench for keypad_ctrl: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_keypad_ctrl;

    localparam int REL = 4;
    localparam int TO  = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] key_code = '0;
    logic        key_valid = 1'b0;
    logic        mlp_done = 1'b0;
    logic [1:0]  mlp_result = 2'b00;
    logic [8:0]  grid;
    logic        mlp_start, busy, result_valid, timeout_err, key_pulse;
    logic [1:0]  result;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int starts   = 0;

    keypad_ctrl #(.RELEASE_CYCLES(REL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .mlp_done(mlp_done), .mlp_result(mlp_result), .grid(grid),
        .mlp_start(mlp_start), .busy(busy), .result(result),
        .result_valid(result_valid), .timeout_err(timeout_err), .key_pulse(key_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: inputs seen through a 2-cycle delay line, modes 0=edit 1=start 2=busy 3=show.
    int          m_mode, m_wait, m_idle;
    bit          m_armed, m_rv, m_te;
    logic [8:0]  m_grid;
    logic [1:0]  m_res;
    logic        m_kv1, m_kv2;
    logic [11:0] m_kc1, m_kc2;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_grid", grid, 0);
            chk("rst_outs", {mlp_start, busy, result, result_valid, timeout_err, key_pulse}, 0);
            m_mode = 0; m_wait = 0; m_idle = 0; m_armed = 1; m_rv = 0; m_te = 0;
            m_grid = '0; m_res = '0; m_kv1 = 0; m_kv2 = 0; m_kc1 = '0; m_kc2 = '0;
        end else begin
            bit acc;
            int k;
            int next_mode;
            acc = m_armed && m_kv2 && ($countones(m_kc2) == 1);
            chk("key_pulse", key_pulse, acc);
            chk("mlp_start", mlp_start, m_mode == 1);
            chk("busy", busy, (m_mode == 1) || (m_mode == 2));
            chk("grid", grid, m_grid);
            chk("result", result, m_res);
            chk("result_valid", result_valid, m_rv);
            chk("timeout_err", timeout_err, m_te);
            if (key_pulse) pulses++;
            if (mlp_start) starts++;

            k = 0;
            for (int i = 0; i < 12; i++) if (m_kc2[i]) k = i;
            next_mode = m_mode;
            if ((m_mode == 0 || m_mode == 3) && acc) begin
                if (m_mode == 3) begin m_rv = 0; m_te = 0; next_mode = 0; end
                if (k < 9) m_grid[k] = ~m_grid[k];
                else if (k == 9) m_grid = '0;
                else if (k == 10) begin m_rv = 0; m_te = 0; end
                else begin m_rv = 0; m_te = 0; next_mode = 1; end
            end else if (m_mode == 1) begin
                m_rv = 0; m_te = 0; m_wait = 0; next_mode = 2;
            end else if (m_mode == 2) begin
                if (mlp_done) begin m_res = mlp_result; m_rv = 1; next_mode = 3; end
                else if (m_wait == TO) begin m_te = 1; next_mode = 3; end
                else m_wait++;
            end
            m_mode = next_mode;

            if (acc) m_armed = 0;
            else if (m_idle >= REL) m_armed = 1;
            m_idle = m_kv2 ? 0 : ((m_idle < REL) ? m_idle + 1 : REL);
            m_kv2 = m_kv1; m_kc2 = m_kc1;
            m_kv1 = key_valid; m_kc1 = key_code;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [11:0] code, input int hold);
        key_code = code; key_valid = 1'b1;
        tick(hold);
        key_valid = 1'b0; key_code = '0;
        tick(REL + 6);
    endtask

    initial begin
        int p0, s0;
        tick(3);
        chk("lit_reset_grid", grid, 9'h000);
        rst = 1'b1;
        tick(2);

        // Held key fires once; second press toggles back.
        p0 = pulses;
        press(12'h010, 3 * REL);
        chk("lit_hold_pulses", pulses - p0, 1);
        chk("lit_grid_5", grid, 9'h010);
        press(12'h010, 2);
        chk("lit_grid_5_off", grid, 9'h000);

        // Draw a diagonal and classify.
        press(12'h001, 2);
        press(12'h010, 2);
        press(12'h100, 2);
        chk("lit_grid_diag", grid, 9'h111);
        s0 = starts;
        press(12'h800, 1);
        chk("lit_one_start", starts - s0, 1);
        chk("lit_busy", busy, 1);
        mlp_done = 1'b1; mlp_result = 2'b01;
        tick(1);
        mlp_done = 1'b0; mlp_result = 2'b00;
        tick(1);
        chk("lit_result_o", result, 2'b01);
        chk("lit_rv", result_valid, 1);
        chk("lit_idle", busy, 0);

        // Key during inference is consumed; then timeout.
        press(12'h800, 1);
        p0 = pulses;
        press(12'h004, 2);
        chk("lit_busy_pulse", pulses - p0, 1);
        chk("lit_busy_grid", grid, 9'h111);
        tick(TO + 10);
        chk("lit_timeout", timeout_err, 1);
        chk("lit_to_result", result, 2'b01);
        chk("lit_to_busy", busy, 0);

        // Clear from SHOW; malformed code ignored.
        press(12'h200, 1);
        chk("lit_star_rv", result_valid, 0);
        chk("lit_star_te", timeout_err, 0);
        chk("lit_star_grid", grid, 9'h000);
        p0 = pulses;
        key_code = 12'h003; key_valid = 1'b1;
        tick(6);
        key_valid = 1'b0; key_code = '0;
        tick(REL + 6);
        chk("lit_multi_nopulse", pulses - p0, 0);
        press(12'h001, 1);
        chk("lit_edit_grid", grid, 9'h001);

        // mlp_done exactly on the expiry cycle.
        key_code = 12'h800; key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0; key_code = '0;
        tick(3 + TO);
        mlp_done = 1'b1; mlp_result = 2'b10;
        tick(1);
        mlp_done = 1'b0; mlp_result = 2'b00;
        tick(1);
        chk("lit_tie_result", result, 2'b10);
        chk("lit_tie_rv", result_valid, 1);
        chk("lit_tie_te", timeout_err, 0);
        tick(REL + 4);

        // Reset mid-inference, then a late completion.
        key_code = 12'h800; key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0; key_code = '0;
        tick(6);
        chk("lit_pre_rst_busy", busy, 1);
        rst = 1'b0;
        tick(1);
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_result", {result, result_valid}, 3'b000);
        chk("lit_rst_grid", grid, 9'h000);
        rst = 1'b1;
        tick(1);
        mlp_done = 1'b1; mlp_result = 2'b01;
        tick(1);
        mlp_done = 1'b0; mlp_result = 2'b00;
        tick(3);
        chk("lit_late_done", {result, result_valid, busy}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_ctrl.md
KEYPAD_CTRL -- requirements
Module: keypad_ctrl

Interface
REQ-001 The block SHALL have parameter RELEASE_CYCLES, default 25000: consecutive clk cycles with no key_valid that re-arm key acceptance.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum clk cycles to wait for mlp_done.
REQ-003 The block SHALL have port clk  input  1  system clock (50 MHz); all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port key_code  input  12  one-hot key from the keypad scanner: bit0..8 = keys 1..9, bit9 = *, bit10 = 0, bit11 = #.
REQ-006 The block SHALL have port key_valid  input  1  key_code qualifier from the keypad scanner.
REQ-007 The block SHALL have port mlp_done  input  1  single-cycle inference-complete pulse.
REQ-008 The block SHALL have port mlp_result  input  2  class, sampled with mlp_done: 01 = O, 10 = X, 00/11 = unknown.
REQ-009 The block SHALL have port grid  output  9  3x3 pixel image; bit n = key n+1.
REQ-010 The block SHALL have port mlp_start  output  1  single-cycle start pulse to the MLP.
REQ-011 The block SHALL have port busy  output  1  high while an inference is outstanding.
REQ-012 The block SHALL have port result  output  2  last captured mlp_result.
REQ-013 The block SHALL have port result_valid  output  1  result holds a fresh classification.
REQ-014 The block SHALL have port timeout_err  output  1  last inference timed out.
REQ-015 The block SHALL have port key_pulse  output  1  one-cycle strobe per accepted key.

Function
REQ-016 key_valid and key_code SHALL pass through a 2-flop synchronizer; all later references mean synchronized values (2-cycle latency).
REQ-017 A key SHALL be accepted when armed=1, key_valid=1 and key_code has exactly one bit set; acceptance SHALL clear armed and assert key_pulse for exactly one cycle.
REQ-018 key_valid=1 with zero or multiple bits set SHALL be ignored and SHALL NOT change armed.
REQ-019 A release counter SHALL reset to 0 on any cycle with key_valid=1, otherwise increment, saturating at RELEASE_CYCLES; reaching RELEASE_CYCLES SHALL set armed=1.
REQ-020 The FSM SHALL have states EDIT, START, BUSY, SHOW; state code width is free.
REQ-021 EDIT: accepted key 1..9 SHALL toggle the corresponding grid bit; * SHALL clear grid to 0; 0 SHALL clear result_valid and timeout_err; # SHALL go to START.
REQ-022 START: mlp_start=1 for this single cycle, busy=1, result_valid=0, timeout_err=0; next state BUSY unconditionally.
REQ-023 BUSY: busy=1; accepted keys SHALL be consumed (key_pulse fires, armed clears) but otherwise ignored; grid SHALL remain stable.
REQ-024 BUSY with mlp_done=1: result<=mlp_result, result_valid<=1, next state SHOW.
REQ-025 BUSY timeout counter SHALL start at 0 on entry; when it reaches TIMEOUT_CYCLES without mlp_done, timeout_err<=1, result unchanged, next state SHOW.
REQ-026 mlp_done and timeout in the same cycle: mlp_done SHALL win; timeout_err stays 0.
REQ-027 mlp_done outside BUSY SHALL be ignored.
REQ-028 SHOW: busy=0, result held; accepted key SHALL clear result_valid and timeout_err, then act per REQ-021 in the same cycle, going to EDIT (1..9, *, 0) or START (#).
REQ-029 mlp_start SHALL never assert in two consecutive cycles.

Reset
REQ-030 While rst=0: state=EDIT, grid=0, mlp_start=0, busy=0, result=00, result_valid=0, timeout_err=0, key_pulse=0, armed=1, counters=0, synchronizers=0.
REQ-031 Reset assertion mid-inference SHALL abort immediately; late mlp_done after release SHALL be ignored (REQ-027).

Verification
REQ-032 Reset, press key 5 (code 0x010) held for 3x RELEASE_CYCLES -> exactly one key_pulse, grid=0x010; release, press 5 again -> grid=0x000.
REQ-033 Press 1, 5, 9, then # -> grid=0x111, one mlp_start pulse, busy=1; mlp_done with mlp_result=01 -> result=01, result_valid=1, busy=0.
REQ-034 In BUSY press 3 -> key_pulse but grid unchanged; no mlp_done for TIMEOUT_CYCLES -> timeout_err=1, state SHOW, result unchanged.
REQ-035 In SHOW press * -> result_valid=0, grid=0x000, EDIT; key_code=0x003 with key_valid -> no key_pulse.
REQ-036 mlp_done and timeout expiry same cycle -> result captured, timeout_err=0; rst=0 during BUSY -> all outputs at reset values next cycle.
